// File: rtl/upsampler_2x_replicate.sv
// rtl/upsampler_2x_replicate.sv - 2x pixel-replicating upsampler with one-row line buffer replay
// Optional build macro: UPSAMPLER_BLANK_ZERO_EN (forces out_data to zero on blanked pixels)
module upsampler_2x_replicate #(
  parameter int IN_COLS = 210,
  parameter int IN_ROWS = 160
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_blank,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_blank,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               copy_q, copy_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         pix_q, pix_d;
  logic               blank_q, blank_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;

  // {blank, data} per input column; rd_data_q always mirrors line_mem[col_q]
  logic [8:0]         line_mem [IN_COLS];
  logic [8:0]         rd_data_q;

  logic               load;
  logic               wr_en;
  logic               col_last;
  logic               row_last;

  assign load     = !out_valid_q || out_ready;
  assign col_last = (col_q == COL_W'(IN_COLS - 1));
  assign row_last = (row_q == ROW_W'(IN_ROWS - 1));
  assign wr_en    = in_valid && in_ready;

  // Next-state, counter and output-register logic; the output register only moves when its slot frees up
  always_comb begin
    state_d     = state_q;
    copy_d      = copy_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    pix_d       = pix_q;
    blank_d     = blank_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    in_ready    = 1'b0;

    case (state_q)
      ST_FILL: begin
        in_ready = !reset && !copy_q && load;
        if (load) begin
          if (copy_q) begin
            // second emission of the pixel already held in the output register
            out_valid_d = 1'b1;
            copy_d      = 1'b0;
            eol_d       = col_last;
            eof_d       = 1'b0;
            if (col_last) begin
              col_d   = '0;
              state_d = ST_REPLAY;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (in_valid) begin
            out_valid_d = 1'b1;
            pix_d       = in_data;
            blank_d     = in_blank;
            eol_d       = 1'b0;
            eof_d       = 1'b0;
            copy_d      = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            eol_d       = 1'b0;
            eof_d       = 1'b0;
          end
        end
      end
      default: begin
        if (load) begin
          out_valid_d = 1'b1;
          if (!copy_q) begin
            // prefetched entry is already waiting in rd_data_q, so no bubble
            pix_d   = rd_data_q[7:0];
            blank_d = rd_data_q[8];
            eol_d   = 1'b0;
            eof_d   = 1'b0;
            copy_d  = 1'b1;
          end else begin
            copy_d = 1'b0;
            eol_d  = col_last;
            eof_d  = col_last && row_last;
            if (col_last) begin
              col_d   = '0;
              state_d = ST_FILL;
              row_d   = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset; reset also restarts frame alignment
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FILL;
      copy_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      pix_q       <= '0;
      blank_q     <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      copy_q      <= copy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      pix_q       <= pix_d;
      blank_q     <= blank_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  // Line buffer: write on accept, read addressed by the next column so the entry is ready one cycle early
  always_ff @(posedge clock) begin
    if (wr_en) begin
      line_mem[col_q] <= {in_blank, in_data};
    end
    rd_data_q <= line_mem[col_d];
  end

  assign out_valid = out_valid_q;
  assign out_blank = blank_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
`ifdef UPSAMPLER_BLANK_ZERO_EN
  assign out_data  = blank_q ? 8'd0 : pix_q;
`else
  assign out_data  = pix_q;
`endif

endmodule

// File: tb/tb_upsampler_2x_replicate.sv
// tb/tb_upsampler_2x_replicate.sv - directed table-driven bench for upsampler_2x_replicate (4x2 frame)
module tb_upsampler_2x_replicate;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_blank = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_blank;
  logic       out_eol;
  logic       out_eof;

  int n_checks = 0;
  int n_errors = 0;
  int got[$];

  upsampler_2x_replicate #(.IN_COLS(4), .IN_ROWS(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_blank (in_blank),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_blank(out_blank),
    .out_eol  (out_eol),
    .out_eof  (out_eof)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       b;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       ee;
    logic       ef;
    logic       eir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [7:0] d, input logic b,
                     input logic ev, input logic [7:0] ed, input logic eb,
                     input logic ee, input logic ef, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.b = b; v.ordy = 1'b1;
    v.ev = ev; v.eb = eb; v.ee = ee; v.ef = ef; v.eir = eir;
`ifdef UPSAMPLER_BLANK_ZERO_EN
    v.ed = eb ? 8'd0 : ed;
`else
    v.ed = ed;
`endif
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // one cycle: drive at negedge, sample 1ns later, log output transfers as {eof,eol,data}
  task automatic cyc(input logic iv, input logic [7:0] d, input logic b, input logic ordy);
    @(negedge clock);
    in_valid = iv; in_data = d; in_blank = b; out_ready = ordy;
    #1;
    if (out_valid && out_ready) got.push_back({22'd0, out_eof, out_eol, out_data});
  endtask

  task automatic do_reset(input string nm);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk({nm, "_rst_valid"}, int'(out_valid), 0);
    chk({nm, "_rst_data"},  int'(out_data), 0);
    chk({nm, "_rst_blank"}, int'(out_blank), 0);
    chk({nm, "_rst_eol"},   int'(out_eol), 0);
    chk({nm, "_rst_eof"},   int'(out_eof), 0);
    chk({nm, "_rst_inrdy"}, int'(in_ready), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({nm, "_post_inrdy"}, int'(in_ready), 1);
  endtask

  task automatic chk_got(input string nm, input int exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_xfer%0d", nm, i), got[i], exp[i]);
  endtask

  initial begin
    int ex[$];

    // full 4x2 frame plus the first pixel of the next frame, out_ready held high
    add(1, 10, 0,  0,  0, 0, 0, 0, 1);
    add(0,  0, 0,  1, 10, 0, 0, 0, 0);
    add(1, 20, 0,  1, 10, 0, 0, 0, 1);
    add(0,  0, 0,  1, 20, 0, 0, 0, 0);
    add(1, 30, 0,  1, 20, 0, 0, 0, 1);
    add(0,  0, 0,  1, 30, 0, 0, 0, 0);
    add(1, 40, 0,  1, 30, 0, 0, 0, 1);
    add(0,  0, 0,  1, 40, 0, 0, 0, 0);
    add(0,  0, 0,  1, 40, 0, 1, 0, 0);
    add(0,  0, 0,  1, 10, 0, 0, 0, 0);
    add(0,  0, 0,  1, 10, 0, 0, 0, 0);
    add(0,  0, 0,  1, 20, 0, 0, 0, 0);
    add(0,  0, 0,  1, 20, 0, 0, 0, 0);
    add(0,  0, 0,  1, 30, 0, 0, 0, 0);
    add(0,  0, 0,  1, 30, 0, 0, 0, 0);
    add(0,  0, 0,  1, 40, 0, 0, 0, 0);
    add(1,  3, 1,  1, 40, 0, 1, 0, 1);
    add(0,  0, 0,  1,  3, 1, 0, 0, 0);
    add(1, 60, 0,  1,  3, 1, 0, 0, 1);
    add(0,  0, 0,  1, 60, 0, 0, 0, 0);
    add(1, 70, 0,  1, 60, 0, 0, 0, 1);
    add(0,  0, 0,  1, 70, 0, 0, 0, 0);
    add(1, 80, 0,  1, 70, 0, 0, 0, 1);
    add(0,  0, 0,  1, 80, 0, 0, 0, 0);
    add(0,  0, 0,  1, 80, 0, 1, 0, 0);
    add(0,  0, 0,  1,  3, 1, 0, 0, 0);
    add(0,  0, 0,  1,  3, 1, 0, 0, 0);
    add(0,  0, 0,  1, 60, 0, 0, 0, 0);
    add(0,  0, 0,  1, 60, 0, 0, 0, 0);
    add(0,  0, 0,  1, 70, 0, 0, 0, 0);
    add(0,  0, 0,  1, 70, 0, 0, 0, 0);
    add(0,  0, 0,  1, 80, 0, 0, 0, 0);
    add(1, 99, 0,  1, 80, 0, 1, 1, 1);
    add(0,  0, 0,  1, 99, 0, 0, 0, 0);
    add(0,  0, 0,  1, 99, 0, 0, 0, 1);

    repeat (2) @(posedge clock);
    do_reset("init");

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].iv, vecs[i].d, vecs[i].b, vecs[i].ordy);
      chk($sformatf("v%0d_valid", i), int'(out_valid), int'(vecs[i].ev));
      chk($sformatf("v%0d_inrdy", i), int'(in_ready), int'(vecs[i].eir));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_data", i),  int'(out_data),  int'(vecs[i].ed));
        chk($sformatf("v%0d_blank", i), int'(out_blank), int'(vecs[i].eb));
        chk($sformatf("v%0d_eol", i),   int'(out_eol),   int'(vecs[i].ee));
        chk($sformatf("v%0d_eof", i),   int'(out_eof),   int'(vecs[i].ef));
      end
    end

    // backpressure: stall three cycles on the first copy of 20
    do_reset("bp");
    got.delete();
    cyc(1, 10, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 20, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("bp_stall%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("bp_stall%0d_data", k),  int'(out_data), 20);
      chk($sformatf("bp_stall%0d_inrdy", k), int'(in_ready), 0);
    end
    cyc(0, 0, 0, 1);
    chk("bp_resume_data", int'(out_data), 20);
    cyc(1, 30, 0, 1);
    chk("bp_second_inrdy", int'(in_ready), 1);
    cyc(0, 0, 0, 1);
    ex = '{10, 10, 20, 20, 30};
    chk_got("bp", ex);

    // reset in the middle of a replay
    do_reset("mid0");
    cyc(1, 10, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 20, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 30, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 40, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("mid_in_replay_inrdy", int'(in_ready), 0);
    do_reset("mid");
    got.delete();
    cyc(1, 55, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("mid_after_inrdy", int'(in_ready), 1);
    cyc(0, 0, 0, 1);
    chk("mid_idle_valid0", int'(out_valid), 0);
    cyc(0, 0, 0, 1);
    chk("mid_idle_valid1", int'(out_valid), 0);
    ex = '{55, 55};
    chk_got("mid", ex);

    // input gaps: in_valid pattern 1,0,0,1 around the accept slots
    do_reset("gap");
    got.delete();
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("gap_a_valid", int'(out_valid), 0);
    chk("gap_a_inrdy", int'(in_ready), 1);
    cyc(1, 2, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("gap_b_valid", int'(out_valid), 0);
    cyc(1, 3, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 4, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    ex = '{1, 1, 2, 2, 3, 3, 4, 256 + 4};
    chk_got("gap", ex);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
